game_collision_detector: RTL and testbench



---
 rtl/game_collision_detector.sv | 148 ++++++++++++++
 tb/tb_game_collision_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/game_collision_detector.sv
// Per-frame sprite overlap detector; confirms overlaps that persist MIN_FRAMES frames.
// Latency: pulse 1 cycle after the confirming frame_end. No backpressure; pulses are fire-and-forget.
// Optional GAME_COLLISION_PIXEL_COUNT_EN: frames need MIN_OVERLAP_PIXELS overlapping pixels.
module game_collision_detector #(
    parameter int MIN_FRAMES         = 2,
    parameter int MIN_OVERLAP_PIXELS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       frame_end,
    input  logic       spaceship_rgb_en,
    input  logic       bullet_rgb_en,
    input  logic [2:0] target_rgb_en,
    output logic       collision,
    output logic       collision_bullet,
    output logic [2:0] hit_target,
    output logic       armed
);

    typedef enum logic {SKIP, ARMED} state_t;

    localparam logic [3:0] MIN_F = 4'(MIN_FRAMES);

    state_t     state, state_nxt;
    logic [3:0] ship_cnt, bul_cnt, ship_cnt_nxt, bul_cnt_nxt;
    logic [3:0] ship_inc, bul_inc;
    logic [2:0] bul_tgt, bul_tgt_now, hit_target_nxt;
    logic       collision_nxt, collision_bullet_nxt;
    logic       ship_px, bul_px, ship_frame, bul_frame;

    assign ship_px     = enable & spaceship_rgb_en & (|target_rgb_en);
    assign bul_px      = enable & bullet_rgb_en & (|target_rgb_en);
    // Frame results include the pixel on the frame_end cycle itself.
    assign bul_tgt_now = bul_tgt | (bul_px ? target_rgb_en : 3'b000);
    assign ship_inc    = ship_cnt + 4'd1;
    assign bul_inc     = bul_cnt + 4'd1;
    assign armed       = (state == ARMED);

`ifdef GAME_COLLISION_PIXEL_COUNT_EN
    localparam logic [8:0] MIN_OVL = 9'(MIN_OVERLAP_PIXELS);

    logic [7:0] ship_pix, bul_pix, ship_pix_now, bul_pix_now;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ship_pix_now = ship_px ? sat_inc(ship_pix) : ship_pix;
    assign bul_pix_now  = bul_px ? sat_inc(bul_pix) : bul_pix;
    assign ship_frame   = ({1'b0, ship_pix_now} >= MIN_OVL);
    assign bul_frame    = ({1'b0, bul_pix_now} >= MIN_OVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_pix <= 8'd0;
            bul_pix  <= 8'd0;
        end else if (clear || frame_end) begin
            ship_pix <= 8'd0;
            bul_pix  <= 8'd0;
        end else begin
            ship_pix <= ship_pix_now;
            bul_pix  <= bul_pix_now;
        end
    end
`else
    logic ship_seen, bul_seen;
    logic unused_min_ovl;

    assign unused_min_ovl = (MIN_OVERLAP_PIXELS != 0);
    assign ship_frame     = ship_seen | ship_px;
    assign bul_frame      = bul_seen | bul_px;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_seen <= 1'b0;
            bul_seen  <= 1'b0;
        end else if (clear || frame_end) begin
            ship_seen <= 1'b0;
            bul_seen  <= 1'b0;
        end else begin
            ship_seen <= ship_frame;
            bul_seen  <= bul_frame;
        end
    end
`endif

    always_comb begin
        state_nxt            = state;
        ship_cnt_nxt         = ship_cnt;
        bul_cnt_nxt          = bul_cnt;
        hit_target_nxt       = hit_target;
        collision_nxt        = 1'b0;
        collision_bullet_nxt = 1'b0;
        if (clear) begin
            state_nxt      = SKIP;
            ship_cnt_nxt   = 4'd0;
            bul_cnt_nxt    = 4'd0;
            hit_target_nxt = 3'b000;
        end else if (frame_end) begin
            case (state)
                SKIP: state_nxt = ARMED;
                ARMED: begin
                    if (!ship_frame) begin
                        ship_cnt_nxt = 4'd0;
                    end else if (ship_inc == MIN_F) begin
                        collision_nxt = 1'b1;
                        ship_cnt_nxt  = 4'd0;
                    end else begin
                        ship_cnt_nxt = ship_inc;
                    end
                    if (!bul_frame) begin
                        bul_cnt_nxt = 4'd0;
                    end else if (bul_inc == MIN_F) begin
                        collision_bullet_nxt = 1'b1;
                        bul_cnt_nxt          = 4'd0;
                        hit_target_nxt       = bul_tgt_now;
                    end else begin
                        bul_cnt_nxt = bul_inc;
                    end
                end
                default: state_nxt = SKIP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= SKIP;
            ship_cnt         <= 4'd0;
            bul_cnt          <= 4'd0;
            bul_tgt          <= 3'b000;
            hit_target       <= 3'b000;
            collision        <= 1'b0;
            collision_bullet <= 1'b0;
        end else begin
            state            <= state_nxt;
            ship_cnt         <= ship_cnt_nxt;
            bul_cnt          <= bul_cnt_nxt;
            bul_tgt          <= (clear || frame_end) ? 3'b000 : bul_tgt_now;
            hit_target       <= hit_target_nxt;
            collision        <= collision_nxt;
            collision_bullet <= collision_bullet_nxt;
        end
    end

endmodule

// File: tb/tb_game_collision_detector.sv
// Frame-level bench: expected {collision, collision_bullet, hit_target, armed} queued at each frame_end.
module tb_game_collision_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       frame_end = 1'b0;
    logic       spaceship_rgb_en = 1'b0;
    logic       bullet_rgb_en = 1'b0;
    logic [2:0] target_rgb_en = 3'b000;
    logic       collision;
    logic       collision_bullet;
    logic [2:0] hit_target;
    logic       armed;

`ifdef GAME_COLLISION_PIXEL_COUNT_EN
    localparam int OVP = 4;
`else
    localparam int OVP = 1;
`endif

    game_collision_detector #(.MIN_FRAMES(2), .MIN_OVERLAP_PIXELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .frame_end(frame_end),
        .spaceship_rgb_en(spaceship_rgb_en), .bullet_rgb_en(bullet_rgb_en),
        .target_rgb_en(target_rgb_en), .collision(collision),
        .collision_bullet(collision_bullet), .hit_target(hit_target), .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         ship;
        bit         bul;
        logic [2:0] tgt;
        int         npx;
        bit         clr;
        logic [5:0] exp;   // {collision, collision_bullet, hit_target, armed}
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] expq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic       fe_seen = 1'b0;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    function automatic logic [5:0] ex(input bit c, input bit cb, input logic [2:0] h, input bit a);
        return {c, cb, h, a};
    endfunction

    task automatic add(input bit en, input bit ship, input bit bul, input logic [2:0] tgt,
                       input int npx, input bit clr, input logic [5:0] exp);
        vec_t v;
        v.en = en; v.ship = ship; v.bul = bul; v.tgt = tgt;
        v.npx = npx; v.clr = clr; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Last ovp pixels overlap; pixels 0/1 place target and sprite apart as decoys.
    task automatic run_frame(input bit en, input bit ship, input bit bul, input logic [2:0] tgt,
                             input int npx, input int ovp, input bit clr, input logic [5:0] exp);
        for (int i = 0; i < npx; i++) begin
            @(posedge clk);
            #1;
            enable = en;
            if (i >= npx - ovp) begin
                spaceship_rgb_en = ship;
                bullet_rgb_en    = bul;
                target_rgb_en    = tgt;
            end else begin
                spaceship_rgb_en = (i == 1);
                bullet_rgb_en    = (i == 1);
                target_rgb_en    = (i == 0) ? tgt : 3'b000;
            end
            frame_end = (i == npx - 1);
            clear     = clr && (i == npx - 1);
            if (i == npx - 1) expq.push_back(exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            frame_end = 1'b0; clear = 1'b0;
            spaceship_rgb_en = 1'b0; bullet_rgb_en = 1'b0; target_rgb_en = 3'b000;
        end
    endtask

    always @(posedge clk) fe_seen <= frame_end;

    always @(negedge clk) begin
        if (fe_seen) begin
            if (expq.size() == 0) check("unexpected_frame", 6'b0, 6'b111111);
            else check("frame", {collision, collision_bullet, hit_target, armed}, expq.pop_front());
        end else begin
            check("idle_pulse", {4'b0, collision, collision_bullet}, 6'b0);
        end
    end

    initial begin
        // reset, skip frame, 2-frame confirm
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(1, 0, 3'b000, 1));
        // yes, no, yes, yes
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 0, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(1, 0, 3'b000, 1));
        // bullet on target 2, hit held; then ship+bullet together
        add(1, 0, 1, 3'b010, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 0, 1, 3'b010, 6, 0, ex(0, 1, 3'b010, 1));
        add(1, 0, 0, 3'b010, 6, 0, ex(0, 0, 3'b010, 1));
        add(1, 1, 1, 3'b100, 6, 0, ex(0, 0, 3'b010, 1));
        add(1, 1, 1, 3'b100, 6, 0, ex(1, 1, 3'b100, 1));
        // clear on the confirming frame_end
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b100, 1));
        add(1, 1, 0, 3'b001, 6, 1, ex(0, 0, 3'b000, 0));
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(1, 0, 3'b000, 1));
        // disabled frame between overlapping frames
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(0, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 1, 0, 3'b001, 6, 0, ex(1, 0, 3'b000, 1));
        // bullet over two targets at once
        add(1, 0, 1, 3'b011, 6, 0, ex(0, 0, 3'b000, 1));
        add(1, 0, 1, 3'b011, 6, 0, ex(0, 1, 3'b011, 1));
`ifndef GAME_COLLISION_PIXEL_COUNT_EN
        // overlap only on the frame_end pixel; then a one-pixel frame
        add(1, 1, 0, 3'b001, 6, 0, ex(0, 0, 3'b011, 1));
        add(1, 1, 0, 3'b001, 1, 0, ex(1, 0, 3'b011, 1));
`endif

        @(posedge clk);
        #1;
        check("reset_state", {collision, collision_bullet, hit_target, armed}, 6'b0);
        rst_n = 1'b1;
        idle(2);

        foreach (vecs[k])
            run_frame(vecs[k].en, vecs[k].ship, vecs[k].bul, vecs[k].tgt,
                      vecs[k].npx, (vecs[k].npx < OVP) ? vecs[k].npx : OVP,
                      vecs[k].clr, vecs[k].exp);
        idle(2);

`ifdef GAME_COLLISION_PIXEL_COUNT_EN
        for (int f = 0; f < 3; f++) run_frame(1, 1, 0, 3'b001, 6, 3, 0, ex(0, 0, 3'b011, 1));
        run_frame(1, 1, 0, 3'b001, 6, 4, 0, ex(0, 0, 3'b011, 1));
        run_frame(1, 1, 0, 3'b001, 6, 4, 0, ex(1, 0, 3'b011, 1));
        // 259 pixels would wrap to 3 without saturation
        run_frame(1, 1, 0, 3'b001, 262, 259, 0, ex(0, 0, 3'b011, 1));
        run_frame(1, 1, 0, 3'b001, 262, 259, 0, ex(1, 0, 3'b011, 1));
        idle(2);
`endif

        // async reset mid-frame while hit_target/armed are non-zero
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            enable = 1'b1; spaceship_rgb_en = 1'b1; target_rgb_en = 3'b001;
        end
        #2 rst_n = 1'b0;
        #1 check("async_reset", {collision, collision_bullet, hit_target, armed}, 6'b0);
        idle(2);
        rst_n = 1'b1;
        run_frame(1, 1, 0, 3'b001, 6, OVP, 0, ex(0, 0, 3'b000, 1));
        run_frame(1, 1, 0, 3'b001, 6, OVP, 0, ex(0, 0, 3'b000, 1));
        run_frame(1, 1, 0, 3'b001, 6, OVP, 0, ex(1, 0, 3'b000, 1));
        idle(3);

        check("queue_drained", 6'(expq.size()), 6'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
